// File: rtl/traffic_timer.sv
// Interval timer for the traffic_light controller: counts out t_length units, flickers near expiry, pulses t_done.
// Optional feature macro: TRAFFIC_TIMER_PAUSE_EN adds a t_pause input that freezes a running interval.
module traffic_timer #(
    parameter int LEN_W         = 5,
    parameter int TICK_DIV      = 10,
    parameter int FLICKER_UNITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_start,
    input  logic [LEN_W-1:0] t_length,
`ifdef TRAFFIC_TIMER_PAUSE_EN
    input  logic             t_pause,
`endif
    output logic             t_done,
    output logic             t_flicker
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(TICK_DIV / 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state, state_next;
    logic [LEN_W-1:0]   remain, remain_next;
    logic [PRESC_W-1:0] presc, presc_next;
    logic               run_hold;

`ifdef TRAFFIC_TIMER_PAUSE_EN
    assign run_hold = t_pause;
`else
    assign run_hold = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            remain <= '0;
            presc  <= '0;
        end else begin
            state  <= state_next;
            remain <= remain_next;
            presc  <= presc_next;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        remain_next = remain;
        presc_next  = presc;
        if (t_start) begin
            // A start always wins: it retriggers a run, overrides pause and restarts out of DONE.
            remain_next = t_length;
            presc_next  = '0;
            state_next  = (t_length != '0) ? RUN : DONE;
        end else begin
            case (state)
                IDLE: ;
                RUN: begin
                    if (!run_hold) begin
                        if (presc == PRESC_MAX) begin
                            presc_next = '0;
                            if (remain == LEN_W'(1)) begin
                                remain_next = '0;
                                state_next  = DONE;
                            end else begin
                                remain_next = remain - 1'b1;
                            end
                        end else begin
                            presc_next = presc + 1'b1;
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Both outputs decode registers only, so they cannot glitch on input changes.
    assign t_done    = (state == DONE);
    assign t_flicker = (state == RUN) && (int'(remain) <= FLICKER_UNITS) && (presc < PRESC_HALF);

endmodule

// File: tb/tb_traffic_timer.sv
// Self-checking bench for traffic_timer: expected t_done cycles and per-cycle t_flicker values are queued
// when each start is driven and consumed by a monitor that samples on the falling edge.
module tb_traffic_timer;

    localparam int LEN_W = 5;
    localparam int T     = 4;
    localparam int F     = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             t_start = 1'b0;
    logic [LEN_W-1:0] t_length = '0;
`ifdef TRAFFIC_TIMER_PAUSE_EN
    logic             t_pause = 1'b0;
`endif
    logic             t_done;
    logic             t_flicker;

    traffic_timer #(
        .LEN_W        (LEN_W),
        .TICK_DIV     (T),
        .FLICKER_UNITS(F)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .t_start  (t_start),
        .t_length (t_length),
`ifdef TRAFFIC_TIMER_PAUSE_EN
        .t_pause  (t_pause),
`endif
        .t_done   (t_done),
        .t_flicker(t_flicker)
    );

    always #5 clk = ~clk;

    // cyc names the cycle that follows each rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int   cyc;
        logic val;
    } flick_t;

    int     done_q[$];
    flick_t flick_q[$];
    bit     mon_en = 1'b0;

    // Reference flicker: k cycles into an interval of len units, active in the last F units, first half of each unit.
    function automatic logic flick_model(input int len, input int k);
        int units_left;
        units_left = len - k / T;
        return (len > 0) && (k < len * T) && (units_left <= F) && ((k % T) < T / 2);
    endfunction

    task automatic push_flick(input int from_cyc, input int len, input int k0, input int n);
        flick_t f;
        for (int i = 0; i < n; i++) begin
            f.cyc = from_cyc + i;
            f.val = flick_model(len, k0 + i);
            flick_q.push_back(f);
        end
    endtask

    always @(negedge clk) begin : monitor
        flick_t f;
        if (mon_en) begin
            if (t_done !== 1'b0) begin
                if (done_q.size() == 0) check("done_unexpected", 32'(t_done), 0);
                else check("done_cycle", cyc, done_q.pop_front());
            end
            while (flick_q.size() > 0 && flick_q[0].cyc <= cyc) begin
                f = flick_q.pop_front();
                check((f.cyc == cyc) ? "flicker" : "flicker_late", 32'(t_flicker), 32'(f.val));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one start pulse; e0 returns the cycle following the edge that sampled it.
    task automatic start(input int len, output int e0);
        @(negedge clk);
        t_start  = 1'b1;
        t_length = LEN_W'(len);
        @(posedge clk);
        #1;
        e0      = cyc;
        t_start = 1'b0;
    endtask

    initial begin
        int e0, e1;

        // Reset for two edges, then a long idle stretch with nothing expected.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", 32'(t_done), 0);
        check("rst_flicker", 32'(t_flicker), 0);
        @(negedge clk);
        reset = 1'b0;
        push_flick(cyc + 1, 0, 0, 50);
        mon_en = 1'b1;
        wait_cycles(51);

        // Length 3: done 12 cycles after the start edge; short interval flickers throughout.
        start(3, e0);
        done_q.push_back(e0 + 12);
        push_flick(e0, 3, 0, 13);
        wait_cycles(16);

        // Length 5: quiet for 8 cycles, then 1,1,0,0 three times, then 0 alongside done.
        start(5, e0);
        done_q.push_back(e0 + 20);
        push_flick(e0, 5, 0, 21);
        wait_cycles(24);

        // Zero length: DONE is entered by the start edge itself; no flicker at all.
        start(0, e0);
        done_q.push_back(e0);
        push_flick(e0, 0, 0, 3);
        wait_cycles(4);

        // Retrigger with length 2 six edges into a length-4 run: one done at E0+14, none at E0+16.
        start(4, e0);
        push_flick(e0, 4, 0, 6);
        wait_cycles(5);
        start(2, e1);
        done_q.push_back(e0 + 14);
        push_flick(e1, 2, 0, 9);
        wait_cycles(12);

        // Start while in DONE: the committed pulse still appears, then the new interval runs.
        start(0, e0);
        done_q.push_back(e0);
        push_flick(e0, 0, 0, 1);
        start(2, e1);
        done_q.push_back(e1 + 8);
        push_flick(e1, 2, 0, 9);
        wait_cycles(11);

        // Start held for ten edges: no done while held, one done a unit after the last start.
        for (int i = 0; i < 10; i++) start(1, e0);
        done_q.push_back(e0 + 4);
        push_flick(e0, 1, 0, 5);
        wait_cycles(7);

        // Reset at E0+5 of a length-3 run aborts it without a done pulse.
        start(3, e0);
        push_flick(e0, 3, 0, 5);
        wait_cycles(4);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_flick(e0 + 5, 0, 0, 20);
        wait_cycles(20);

`ifdef TRAFFIC_TIMER_PAUSE_EN
        // Pause across edges E0+3..E0+7 freezes the run, pushing done from E0+12 to E0+17.
        start(3, e0);
        done_q.push_back(e0 + 17);
        for (int c = 0; c <= 17; c++) begin
            push_flick(e0 + c, 3, (c < 3) ? c : ((c < 8) ? 2 : c - 5), 1);
        end
        wait_cycles(2);
        @(negedge clk);
        t_pause = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        t_pause = 1'b0;
        wait_cycles(14);
`endif

        wait_cycles(2);
        check("done_pending", done_q.size(), 0);
        check("flicker_pending", flick_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
